dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-state cycles waited for bus_ack before abort (legal range 1..255).
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF, value returned on mem_din for an aborted read.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 mem_ren  input  1  MEM-stage read request from the datapath.
REQ-006 mem_wen  input  1  MEM-stage write request from the datapath.
REQ-007 mem_addr  input  32  byte address from the datapath.
REQ-008 mem_dout  input  32  write data from the datapath.
REQ-009 mem_din  output  32  read data returned to the datapath.
REQ-010 mem_stall  output  1  freeze request to the pipeline controller; holds IF..MEM while 1.
REQ-011 bus_req  output  1  bus request; registered.
REQ-012 bus_we  output  1  1 = write, 0 = read; registered.
REQ-013 bus_addr  output  32  word-aligned bus address; registered.
REQ-014 bus_wdata  output  32  bus write data; registered.
REQ-015 bus_ack  input  1  one-cycle completion pulse from the memory.
REQ-016 bus_rdata  input  32  read data, valid in the bus_ack cycle.
REQ-017 align_err  output  1  sticky misaligned-access flag.
REQ-018 timeout_err  output  1  sticky bus-timeout flag.

Function
REQ-019 States: IDLE, ACCESS, DONE; the state register is the only control state besides the timeout counter and the data/flag registers.
REQ-020 IDLE, (mem_ren|mem_wen)=1, mem_addr[1:0]=0: mem_stall=1 combinationally that cycle; on the edge, latch bus_addr=mem_addr, bus_wdata=mem_dout, bus_we=mem_wen, set bus_req=1, clear counter, go ACCESS.
REQ-021 mem_ren and mem_wen both 1: treat as write (bus_we=1); the read is discarded.
REQ-022 IDLE with request and mem_addr[1:0]!=0: no bus transaction; mem_stall=1 that cycle; set align_err; load read-data register with ERR_DATA; go DONE.
REQ-023 ACCESS: mem_stall=1; bus_req, bus_we, bus_addr, bus_wdata held stable; counter increments each cycle without bus_ack.
REQ-024 ACCESS with bus_ack=1: read-data register <= bus_rdata on reads (unchanged on writes); bus_req <= 0; go DONE.
REQ-025 ACCESS, counter = TIMEOUT_CYCLES-1 and bus_ack=0: bus_req <= 0; set timeout_err; read-data register <= ERR_DATA on reads; go DONE.
REQ-026 bus_ack and timeout in the same cycle: bus_ack wins; timeout_err not set.
REQ-027 DONE: mem_stall=0 for exactly one cycle so the pipeline advances; unconditionally go IDLE; a request visible in DONE is not started.
REQ-028 mem_din always equals the read-data register; the datapath samples it only when mem_stall=0.
REQ-029 bus_ack received in IDLE or DONE is ignored; no state or data change.
REQ-030 IDLE with no request: mem_stall=0, no bus activity.
REQ-031 Minimum access latency: request cycle + 1 ACCESS cycle (ack on first bus_req cycle) + DONE = 3 cycles from request to pipeline release.
REQ-032 align_err and timeout_err remain 1 until rst; they never alter subsequent access behaviour.

Reset
REQ-033 rst=1 forces immediately: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, counter=0, read-data register=0 (mem_din=0), align_err=0, timeout_err=0.
REQ-034 rst asserted during ACCESS drops bus_req in the same cycle without waiting for a clock edge; a later bus_ack for that access is ignored.
REQ-035 mem_stall after reset follows REQ-020/REQ-030 from IDLE.

Verification
REQ-036 Read: mem_ren=1, addr 0x0000_0010; ack after 2 cycles with bus_rdata 0x1234_5678 -> bus_req high 2 cycles, mem_stall high 3 cycles then low 1, mem_din=0x1234_5678.
REQ-037 Write: mem_wen=1, addr 0x20, dout 0xCAFE_0001, immediate ack -> bus_we=1, bus_wdata=0xCAFE_0001, mem_stall sequence 1,1,0.
REQ-038 Misaligned: mem_ren=1, addr 0x0000_0013 -> bus_req never asserts, align_err=1, mem_din=0xFFFF_FFFF, stall 1 then 0.
REQ-039 Timeout: TIMEOUT_CYCLES=4, read, no ack -> bus_req high exactly 4 cycles, timeout_err=1, mem_din=0xFFFF_FFFF; same case with ack in cycle 4 -> no timeout_err, mem_din=bus_rdata.
REQ-040 Reset mid-access: assert rst between clock edges in ACCESS -> bus_req 0 before the next edge, all outputs at reset values; late bus_ack causes no change.
REQ-041 Back-to-back: two reads held consecutively -> second bus_req rises only after DONE/IDLE; both mem_din values correct in order.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage datapath port and single-master memory bus seen by the dmem_bridge.
`default_nettype none

interface dmem_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        align_err;
  logic        timeout_err;

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
    output mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata,
           align_err, timeout_err
  );

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
    input  mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata,
           align_err, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_bridge.sv
// dmem_bridge: stalls the pipeline while one MEM-stage access runs on a req/ack bus,
// with misalignment and timeout detection. Rev 1.0
`default_nettype none

module dmem_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  wire logic clk,
  input  wire logic rst,
  dmem_if.slave     dm
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] c_last_cnt = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_align_err;
  logic        r_timeout_err;

  logic w_req;
  logic w_aligned;

  assign w_req     = dm.mem_ren | dm.mem_wen;
  assign w_aligned = (dm.mem_addr[1:0] == 2'b00);

  // The request cycle itself stalls, so the datapath never moves past an
  // access before the bridge has had a chance to latch it.
  assign dm.mem_stall   = ((r_state == IDLE) && w_req) || (r_state == ACCESS);
  assign dm.mem_din     = r_rdata;
  assign dm.bus_req     = r_req;
  assign dm.bus_we      = r_we;
  assign dm.bus_addr    = r_addr;
  assign dm.bus_wdata   = r_wdata;
  assign dm.align_err   = r_align_err;
  assign dm.timeout_err = r_timeout_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= 8'd0;
      r_rdata       <= 32'd0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_align_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_aligned) begin
              r_addr  <= dm.mem_addr;
              r_wdata <= dm.mem_dout;
              r_we    <= dm.mem_wen;
              r_req   <= 1'b1;
              r_cnt   <= 8'd0;
              r_state <= ACCESS;
            end else begin
              r_align_err <= 1'b1;
              r_rdata     <= ERR_DATA;
              r_state     <= DONE;
            end
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle still completes the access.
          if (dm.bus_ack) begin
            if (!r_we) begin
              r_rdata <= dm.bus_rdata;
            end
            r_req   <= 1'b0;
            r_state <= DONE;
          end else if (r_cnt == c_last_cnt) begin
            if (!r_we) begin
              r_rdata <= ERR_DATA;
            end
            r_timeout_err <= 1'b1;
            r_req         <= 1'b0;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: random datapath requests and memory ack delays, scoreboarded
// against a transaction-level model of the bridge.
`default_nettype none

module tb_dmem_bridge;
  localparam int          T    = 4;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;
  localparam int          NTX  = 300;

  typedef struct {
    logic [31:0] din;
    logic        al;
    logic        to;
    int          stall;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } bus_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   directed = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  bus_t bus_q[$];

  dmem_if dm ();

  dmem_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut (
    .clk (clk),
    .rst (rst),
    .dm  (dm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Memory responder: checks the bus request and acks after the planned delay.
  initial begin
    bit   active = 0;
    int   c = 0;
    bus_t cur;
    dm.bus_ack   = 1'b0;
    dm.bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!directed) begin
        if (dm.bus_req) begin
          if (!active) begin
            active = 1;
            c = 0;
            if (bus_q.size() == 0) begin
              chk("unexpected_bus_req", 32'd1, 32'd0);
              cur = '{addr: 32'd0, we: 1'b0, wdata: 32'd0, delay: 0, rdata: 32'd0};
            end else begin
              cur = bus_q.pop_front();
              chk("bus_addr", dm.bus_addr, cur.addr);
              chk("bus_we", {31'd0, dm.bus_we}, {31'd0, cur.we});
              if (cur.we) chk("bus_wdata", dm.bus_wdata, cur.wdata);
            end
          end
          c++;
          dm.bus_ack   = (c == cur.delay);
          dm.bus_rdata = dm.bus_ack ? cur.rdata : $urandom;
        end else begin
          if (active) begin
            active = 0;
            chk("bus_req_cycles", c, (cur.delay >= 1 && cur.delay <= T) ? cur.delay : T);
          end
          dm.bus_ack   = ($urandom_range(0, 5) == 0);
          dm.bus_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: a completion is a requesting cycle with the stall released.
  initial begin
    int   sc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!directed && !rst && (dm.mem_ren || dm.mem_wen)) begin
        if (dm.mem_stall) begin
          sc++;
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_release", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("mem_din", dm.mem_din, e.din);
            chk("align_err", {31'd0, dm.align_err}, {31'd0, e.al});
            chk("timeout_err", {31'd0, dm.timeout_err}, {31'd0, e.to});
            chk("stall_cycles", sc, e.stall);
          end
          sc = 0;
        end
      end
    end
  end

  // Driver plus reference model.
  initial begin
    logic [31:0] m_din = 32'd0;
    logic        m_al  = 1'b0;
    logic        m_to  = 1'b0;
    dm.mem_ren  = 1'b0;
    dm.mem_wen  = 1'b0;
    dm.mem_addr = 32'd0;
    dm.mem_dout = 32'd0;

    #2;
    chk("rst_bus_req", {31'd0, dm.bus_req}, 32'd0);
    chk("rst_mem_din", dm.mem_din, 32'd0);
    chk("rst_bus_addr", dm.bus_addr, 32'd0);
    chk("rst_flags", {30'd0, dm.align_err, dm.timeout_err}, 32'd0);
    chk("rst_stall", {31'd0, dm.mem_stall}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NTX; i++) begin
      int          k;
      int          dly;
      int          st;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      bit          released;
      k   = $urandom_range(0, 2);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d   = $urandom;
      rd  = $urandom;
      dly = $urandom_range(0, 6);
      we  = (k != 0);

      if (a[1:0] != 2'b00) begin
        m_al  = 1'b1;
        m_din = ERRD;
        st    = 1;
      end else begin
        bus_q.push_back('{addr: a, we: we, wdata: d, delay: dly, rdata: rd});
        if (dly >= 1 && dly <= T) begin
          if (!we) m_din = rd;
          st = dly + 1;
        end else begin
          m_to = 1'b1;
          if (!we) m_din = ERRD;
          st = T + 1;
        end
      end
      exp_q.push_back('{din: m_din, al: m_al, to: m_to, stall: st});

      @(posedge clk); #1;
      dm.mem_ren  = (k != 1);
      dm.mem_wen  = (k != 0);
      dm.mem_addr = a;
      dm.mem_dout = d;

      released = 0;
      for (int w = 0; w < 50 && !released; w++) begin
        @(negedge clk);
        if (!dm.mem_stall) released = 1;
      end
      if (!released) chk("release_timeout", 32'd0, 32'd1);

      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        dm.mem_ren = 1'b0;
        dm.mem_wen = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end

    @(posedge clk); #1;
    dm.mem_ren = 1'b0;
    dm.mem_wen = 1'b0;
    repeat (4) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);

    // Asynchronous reset in the middle of an access, then a stale ack.
    directed = 1'b1;
    dm.bus_ack = 1'b0;
    @(posedge clk); #1;
    dm.mem_ren  = 1'b1;
    dm.mem_addr = 32'h0000_0040;
    @(posedge clk); #1;
    chk("acc_bus_req", {31'd0, dm.bus_req}, 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_bus_req", {31'd0, dm.bus_req}, 32'd0);
    chk("arst_mem_din", dm.mem_din, 32'd0);
    chk("arst_bus_addr", dm.bus_addr, 32'd0);
    chk("arst_flags", {30'd0, dm.align_err, dm.timeout_err}, 32'd0);
    dm.mem_ren = 1'b0;
    @(posedge clk); #1;
    rst          = 1'b0;
    dm.bus_ack   = 1'b1;
    dm.bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dm.bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_din", dm.mem_din, 32'd0);
    chk("late_ack_req", {31'd0, dm.bus_req}, 32'd0);
    chk("late_ack_stall", {31'd0, dm.mem_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
